// File: rtl/bp_pkg.sv
// bp_pkg: shared types and defaults for the branch resolve controller
package bp_pkg;
    localparam int BP_DEPTH_DEF = 4;
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_entry_t;
    typedef enum logic {BP_RUN, BP_FLUSH} bp_state_t;
endpackage

// File: rtl/bp_ckpt_fifo.sv
// bp_ckpt_fifo: in-order checkpoint queue of IF predictions
// ports: clk, rstn (async low), push/pop/clear (clear wins), din, full, empty, head (oldest entry)
module bp_ckpt_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bp_entry_t din,
    output logic      full,
    output logic      empty,
    output bp_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    bp_entry_t      mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    cnt;
    logic           do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rp];
    // a pop frees the slot in the same cycle, so a full queue may still accept
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= do_push ? wp + 1'b1 : wp;
            rp  <= do_pop ? rp + 1'b1 : rp;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wp] <= din;
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: checks EX branch outcomes against queued IF predictions, flushes and redirects on mispredict
// ports: clk, rstn (async low); IF push side if_*; EX resolve side ex_*; stall_if, flush, redirect_*,
//        predictor update upd_*, sticky seq_err, branch_cnt / mispred_cnt
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH        = BP_DEPTH_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             if_push,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic [31:0]      if_pred_target,
    input  logic             ex_resolve,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             stall_if,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic             seq_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    bp_state_t  state, state_n;
    logic [FW-1:0] fcnt, fcnt_n;
    bp_entry_t  head;
    logic       empty, full, acc, pc_err, pred_taken, mis, push;
    bp_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (acc),
        .clear (mis),
        .din   ('{pc: if_pc, taken: if_pred_taken, target: if_pred_target}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    assign acc        = ex_resolve & (state == BP_RUN);
    assign pc_err     = empty | (head.pc != ex_pc);
    // an empty queue behaves as an implicit not-taken prediction
    assign pred_taken = ~empty & head.taken;
    assign mis        = acc & (pc_err | (pred_taken != ex_taken) | (ex_taken & head.target != ex_target));
    // wrong-path pushes in a mispredict cycle are discarded along with the queue
    assign push       = if_push & (state == BP_RUN) & ~mis;
    assign stall_if   = full;
    assign flush      = state == BP_FLUSH;
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        if (state == BP_RUN) begin
            state_n = mis ? BP_FLUSH : BP_RUN;
            fcnt_n  = FW'(FLUSH_CYCLES - 1);
        end else begin
            state_n = (fcnt == '0) ? BP_RUN : BP_FLUSH;
            fcnt_n  = fcnt - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= BP_RUN;
            fcnt           <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            seq_err        <= 1'b0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            state          <= state_n;
            fcnt           <= fcnt_n;
            redirect_valid <= mis;
            redirect_pc    <= ex_taken ? ex_target : ex_pc + 32'd4;
            upd_valid      <= acc;
            upd_pc         <= ex_pc;
            upd_taken      <= ex_taken;
            seq_err        <= seq_err | (acc & pc_err);
            branch_cnt     <= branch_cnt + CNT_W'(acc);
            mispred_cnt    <= mispred_cnt + CNT_W'(mis);
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_push = 1'b0, if_pred_taken = 1'b0;
    logic [31:0] if_pc = '0, if_pred_target = '0;
    logic        ex_resolve = 1'b0, ex_taken = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0;
    logic        stall_if, flush, redirect_valid, upd_valid, upd_taken, seq_err;
    logic [31:0] redirect_pc, upd_pc, branch_cnt, mispred_cnt;
    int checks = 0;
    int failures = 0;

    branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .if_push(if_push), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_resolve(ex_resolve), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .stall_if(stall_if), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .seq_err(seq_err),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if_push    = 1'b0;
        ex_resolve = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        if_push = 1'b1; if_pc = pc; if_pred_taken = t; if_pred_target = tgt;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        ex_resolve = 1'b1; ex_pc = pc; ex_taken = t; ex_target = tgt;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({stall_if, flush, redirect_valid, upd_valid, upd_taken, seq_err} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {stall_if, flush, redirect_valid, upd_valid, upd_taken, seq_err}); end
        checks++; if ({redirect_pc, upd_pc, branch_cnt, mispred_cnt} !== 128'b0) begin failures++; $display("FAIL reset_words got=%h exp=0", {redirect_pc, upd_pc, branch_cnt, mispred_cnt}); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_correct_nt();
        set_push(32'h100, 1'b0, 32'h0); tick();
        set_res(32'h100, 1'b0, 32'h0); tick();
        checks++; if (upd_valid !== 1'b1) begin failures++; $display("FAIL nt_upd_valid got=%b exp=1", upd_valid); end
        checks++; if (upd_pc !== 32'h100) begin failures++; $display("FAIL nt_upd_pc got=%h exp=100", upd_pc); end
        checks++; if ({upd_taken, flush, redirect_valid} !== 3'b000) begin failures++; $display("FAIL nt_flags got=%b exp=000", {upd_taken, flush, redirect_valid}); end
        checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin failures++; $display("FAIL nt_cnt got=%0d/%0d exp=1/0", branch_cnt, mispred_cnt); end
        tick();
        checks++; if (upd_valid !== 1'b0) begin failures++; $display("FAIL nt_upd_pulse got=%b exp=0", upd_valid); end
    endtask

    task automatic test_dir_mispred();
        set_push(32'h200, 1'b0, 32'h0); tick();
        set_res(32'h200, 1'b1, 32'h80); tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin failures++; $display("FAIL dir_redirect got=%b/%h exp=1/80", redirect_valid, redirect_pc); end
        checks++; if (flush !== 1'b1 || upd_taken !== 1'b1) begin failures++; $display("FAIL dir_flush1 got=%b/%b exp=1/1", flush, upd_taken); end
        checks++; if (branch_cnt !== 32'd2 || mispred_cnt !== 32'd1) begin failures++; $display("FAIL dir_cnt got=%0d/%0d exp=2/1", branch_cnt, mispred_cnt); end
        tick();
        checks++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL dir_flush2 got=%b/%b exp=1/0", flush, redirect_valid); end
        tick();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL dir_flush_end got=%b exp=0", flush); end
    endtask

    task automatic test_target_mispred();
        set_push(32'h10, 1'b1, 32'h40); tick();
        set_push(32'h14, 1'b0, 32'h0); tick();
        set_push(32'h18, 1'b0, 32'h0); tick();
        set_res(32'h10, 1'b1, 32'h44); tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin failures++; $display("FAIL tgt_redirect got=%b/%h exp=1/44", redirect_valid, redirect_pc); end
        checks++; if (mispred_cnt !== 32'd2 || seq_err !== 1'b0) begin failures++; $display("FAIL tgt_cnt got=%0d/%b exp=2/0", mispred_cnt, seq_err); end
        set_push(32'h20, 1'b0, 32'h0); tick();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL tgt_flush2 got=%b exp=1", flush); end
        tick();
        set_res(32'h14, 1'b0, 32'h0); tick();
        checks++; if (seq_err !== 1'b1 || redirect_pc !== 32'h18) begin failures++; $display("FAIL tgt_seq_err got=%b/%h exp=1/18", seq_err, redirect_pc); end
        checks++; if (branch_cnt !== 32'd4 || mispred_cnt !== 32'd3) begin failures++; $display("FAIL tgt_cnt2 got=%0d/%0d exp=4/3", branch_cnt, mispred_cnt); end
        tick(); tick();
    endtask

    task automatic test_full();
        logic [31:0] order [4];
        order = '{32'h1004, 32'h1008, 32'h100C, 32'h1014};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h1000 + 32'(i * 4), 1'b0, 32'h0); tick();
        end
        set_push(32'h1010, 1'b0, 32'h0);
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", stall_if); end
        tick();
        set_push(32'h1014, 1'b0, 32'h0);
        set_res(32'h1000, 1'b0, 32'h0); tick();
        checks++; if (stall_if !== 1'b1 || upd_pc !== 32'h1000 || mispred_cnt !== 32'd0) begin failures++; $display("FAIL full_pushpop got=%b/%h/%0d exp=1/1000/0", stall_if, upd_pc, mispred_cnt); end
        for (int i = 0; i < 4; i++) begin
            set_res(order[i], 1'b0, 32'h0); tick();
            checks++; if (upd_pc !== order[i] || mispred_cnt !== 32'd0 || seq_err !== 1'b0) begin failures++; $display("FAIL full_order%0d got=%h/%0d/%b exp=%h/0/0", i, upd_pc, mispred_cnt, seq_err, order[i]); end
        end
        checks++; if (stall_if !== 1'b0 || branch_cnt !== 32'd5) begin failures++; $display("FAIL full_drain got=%b/%0d exp=0/5", stall_if, branch_cnt); end
    endtask

    task automatic test_wrap_and_async_reset();
        apply_reset();
        set_push(32'hFFFFFFFC, 1'b1, 32'h40); tick();
        set_res(32'hFFFFFFFC, 1'b0, 32'h0); tick();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || flush !== 1'b1) begin failures++; $display("FAIL wrap_redirect got=%b/%h/%b exp=1/0/1", redirect_valid, redirect_pc, flush); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if ({flush, redirect_valid, upd_valid} !== 3'b000) begin failures++; $display("FAIL arst_flags got=%b exp=000", {flush, redirect_valid, upd_valid}); end
        checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
        #1;
        rstn = 1'b1;
        set_res(32'h300, 1'b0, 32'h0); tick();
        checks++; if (seq_err !== 1'b1 || flush !== 1'b1 || branch_cnt !== 32'd1 || redirect_pc !== 32'h304) begin failures++; $display("FAIL arst_after got=%b/%b/%0d/%h exp=1/1/1/304", seq_err, flush, branch_cnt, redirect_pc); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_correct_nt();
        test_dir_mispred();
        test_target_mispred();
        test_full();
        test_wrap_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
